// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared definitions for the multi-cycle MIPS-subset control unit.
//   - state_t        : FSM state codes (IF/ID/EXE/MEM/WB)
//   - OP_* / FN_*    : opcode and funct field constants
//   - aluc_t/pcsrc_t : ALU operation and next-PC select encodings
//   - iclass_t       : one-hot instruction class produced by instr_decode
//   - sel_t          : decode-derived datapath selects
//   - decode_selects : maps an instruction class to its selects
package mcpu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } aluc_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b10,
    PC_JUMP   = 2'b11
  } pcsrc_t;

  typedef struct packed {
    logic r_add;
    logic r_sub;
    logic r_and;
    logic r_or;
    logic addi;
    logic andi;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
  } iclass_t;

  typedef struct packed {
    aluc_t aluc;
    logic  aluqb;
    logic  se;
    logic  regrt;
    logic  reg2reg;
  } sel_t;

  function automatic sel_t decode_selects(input iclass_t c);
    sel_t s;
    s = '0;
    if (c.r_add | c.r_sub | c.r_and | c.r_or) begin
      s.aluqb   = 1'b1;
      s.reg2reg = 1'b1;
      if (c.r_sub) s.aluc = ALU_SUB;
      if (c.r_and) s.aluc = ALU_AND;
      if (c.r_or)  s.aluc = ALU_OR;
    end
    if (c.addi | c.andi | c.ori) begin
      s.regrt   = 1'b1;
      s.reg2reg = 1'b1;
      s.se      = c.addi;
      if (c.andi) s.aluc = ALU_AND;
      if (c.ori)  s.aluc = ALU_OR;
    end
    // lw/sw address generation: base + sign-extended offset
    if (c.lw | c.sw) begin
      s.se    = 1'b1;
      s.regrt = c.lw;
    end
    // branch compare: rs - rt, sign-extended offset feeds the target adder
    if (c.beq | c.bne) begin
      s.aluc  = ALU_SUB;
      s.aluqb = 1'b1;
      s.se    = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational Op/Func decode into a one-hot instruction
// class. Anything outside the supported subset raises illegal with an
// all-zero class.
//   op      in  6  opcode field
//   func    in  6  funct field (used when op is R-type)
//   iclass  out    one-hot instruction class
//   illegal out 1  undefined Op/Func combination
module instr_decode
  import mcpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    iclass,
  output logic       illegal
);

  always_comb begin
    iclass  = '0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  iclass.r_add = 1'b1;
          FN_SUB:  iclass.r_sub = 1'b1;
          FN_AND:  iclass.r_and = 1'b1;
          FN_OR:   iclass.r_or  = 1'b1;
          default: illegal      = 1'b1;
        endcase
      end
      OP_ADDI: iclass.addi = 1'b1;
      OP_ANDI: iclass.andi = 1'b1;
      OP_ORI:  iclass.ori  = 1'b1;
      OP_LW:   iclass.lw   = 1'b1;
      OP_SW:   iclass.sw   = 1'b1;
      OP_BEQ:  iclass.beq  = 1'b1;
      OP_BNE:  iclass.bne  = 1'b1;
      OP_J:    iclass.j    = 1'b1;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the MIPS-subset CPU.
// Sequences the shared datapath through IF/ID/EXE/MEM/WB.
//   Clk     in  1  rising-edge clock
//   Clrn    in  1  asynchronous active-low reset
//   Op      in  6  opcode from IR
//   Func    in  6  funct from IR
//   Z       in  1  ALU zero flag, looked at only in EXE for branches
//   Mrdy    in  1  memory ready (only when MEM_WAIT_EN is defined)
//   Wpc/Wir/Wreg/Wmem out 1  write enables (forced low while Clrn=0)
//   Pcsrc   out 2  next-PC select
//   Aluc    out 2  ALU operation
//   Aluqb/Se/Regrt/Reg2reg out 1  datapath selects
//   Illegal out 1  undefined instruction seen in ID
//   State   out 3  current state code
// Build option: define MEM_WAIT_EN to add Mrdy and let MEM stall.
module multicycle_ctrl
  import mcpu_pkg::*;
(
  input  logic       Clk,
  input  logic       Clrn,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Z,
`ifdef MEM_WAIT_EN
  input  logic       Mrdy,
`endif
  output logic       Wpc,
  output logic       Wir,
  output logic       Wreg,
  output logic       Wmem,
  output logic [1:0] Pcsrc,
  output logic [1:0] Aluc,
  output logic       Aluqb,
  output logic       Se,
  output logic       Regrt,
  output logic       Reg2reg,
  output logic       Illegal,
  output logic [2:0] State
);

  state_t  state_q, next_state;
  iclass_t iclass;
  logic    dec_illegal;
  sel_t    sel_dec, sel;
  logic    wpc, wir, wreg, wmem, illegal;
  pcsrc_t  pcsrc;
  logic    is_arith, mem_done;

  instr_decode u_decode (
    .op      (Op),
    .func    (Func),
    .iclass  (iclass),
    .illegal (dec_illegal)
  );

  assign sel_dec  = decode_selects(iclass);
  assign is_arith = iclass.r_add | iclass.r_sub | iclass.r_and | iclass.r_or |
                    iclass.addi | iclass.andi | iclass.ori;

`ifdef MEM_WAIT_EN
  assign mem_done = Mrdy;
`else
  assign mem_done = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) state_q <= S_IF;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state = S_IF;
    wpc        = 1'b0;
    wir        = 1'b0;
    wreg       = 1'b0;
    wmem       = 1'b0;
    pcsrc      = PC_SEQ;
    sel        = '0;
    illegal    = 1'b0;
    case (state_q)
      S_IF: begin
        wir        = 1'b1;
        wpc        = 1'b1;
        next_state = S_ID;
      end
      S_ID: begin
        sel = sel_dec;
        if (iclass.j) begin
          wpc   = 1'b1;
          pcsrc = PC_JUMP;
        end else if (dec_illegal) begin
          illegal = 1'b1;
        end else begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        sel = sel_dec;
        if (is_arith) begin
          next_state = S_WB;
        end else if (iclass.lw | iclass.sw) begin
          next_state = S_MEM;
        end else if ((iclass.beq & Z) | (iclass.bne & ~Z)) begin
          wpc   = 1'b1;
          pcsrc = PC_BRANCH;
        end
      end
      S_MEM: begin
        sel  = sel_dec;
        // sw keeps Wmem asserted for every stalled cycle
        wmem = iclass.sw;
        if (!mem_done)      next_state = S_MEM;
        else if (iclass.lw) next_state = S_WB;
      end
      S_WB: begin
        sel  = sel_dec;
        wreg = 1'b1;
      end
      default: next_state = S_IF;
    endcase
  end

  // Reset forces IF, whose strobes are high; gate everything with Clrn so
  // nothing is written while reset is held.
  assign Wpc     = wpc  & Clrn;
  assign Wir     = wir  & Clrn;
  assign Wreg    = wreg & Clrn;
  assign Wmem    = wmem & Clrn;
  assign Pcsrc   = pcsrc & {2{Clrn}};
  assign Aluc    = sel.aluc & {2{Clrn}};
  assign Aluqb   = sel.aluqb & Clrn;
  assign Se      = sel.se & Clrn;
  assign Regrt   = sel.regrt & Clrn;
  assign Reg2reg = sel.reg2reg & Clrn;
  assign Illegal = illegal & Clrn;
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       Clk = 1'b0;
  logic       Clrn;
  logic [5:0] Op, Func;
  logic       Z;
`ifdef MEM_WAIT_EN
  logic       Mrdy;
`endif
  logic       Wpc, Wir, Wreg, Wmem, Aluqb, Se, Regrt, Reg2reg, Illegal;
  logic [1:0] Pcsrc, Aluc;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .Clk     (Clk),
    .Clrn    (Clrn),
    .Op      (Op),
    .Func    (Func),
    .Z       (Z),
`ifdef MEM_WAIT_EN
    .Mrdy    (Mrdy),
`endif
    .Wpc     (Wpc),
    .Wir     (Wir),
    .Wreg    (Wreg),
    .Wmem    (Wmem),
    .Pcsrc   (Pcsrc),
    .Aluc    (Aluc),
    .Aluqb   (Aluqb),
    .Se      (Se),
    .Regrt   (Regrt),
    .Reg2reg (Reg2reg),
    .Illegal (Illegal),
    .State   (State)
  );

  always #5 Clk = ~Clk;

  // selects packed as {Aluc, Aluqb, Se, Regrt, Reg2reg}
  localparam logic [5:0] SEL_NONE = 6'b00_0000;
  localparam logic [5:0] SEL_ADD  = 6'b00_1001;
  localparam logic [5:0] SEL_SUB  = 6'b01_1001;
  localparam logic [5:0] SEL_ADDI = 6'b00_0111;
  localparam logic [5:0] SEL_ORI  = 6'b11_0011;
  localparam logic [5:0] SEL_LW   = 6'b00_0110;
  localparam logic [5:0] SEL_SW   = 6'b00_0100;
  localparam logic [5:0] SEL_BR   = 6'b01_1100;

  // strobes packed as {Wpc, Wir, Wreg, Wmem}
  function automatic logic [12:0] ctl(input logic [3:0] strb, input logic [1:0] pcs,
                                       input logic [5:0] sel, input logic ill);
    return {strb, pcs, sel, ill};
  endfunction

  localparam logic [12:0] IFC  = {4'b1100, 2'b00, 6'b00_0000, 1'b0};
  localparam logic [12:0] ZERO = '0;

  logic [12:0] obs;
  assign obs = {Wpc, Wir, Wreg, Wmem, Pcsrc, Aluc, Aluqb, Se, Regrt, Reg2reg, Illegal};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Called at a falling edge with inputs already set; checks, then moves
  // on to the next falling edge.
  task automatic step(input string tag, input logic [2:0] st, input logic [12:0] c);
    #1;
    chk({tag, "/state"}, 32'(State), 32'(st));
    chk({tag, "/ctl"}, 32'(obs), 32'(c));
    @(negedge Clk);
  endtask

  initial begin
    Clrn = 1'b0;
    Op   = 6'b000000;
    Func = 6'b100000;
    Z    = 1'b0;
`ifdef MEM_WAIT_EN
    Mrdy = 1'b1;
`endif
    @(negedge Clk);
    step("reset", 3'b000, ZERO);
    Clrn = 1'b1;

    // add
    step("add_if",  3'b000, IFC);
    step("add_id",  3'b001, ctl(4'b0000, 2'b00, SEL_ADD, 1'b0));
    step("add_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_ADD, 1'b0));
    step("add_wb",  3'b100, ctl(4'b0010, 2'b00, SEL_ADD, 1'b0));

    // sub
    Func = 6'b100010;
    step("sub_if",  3'b000, IFC);
    step("sub_id",  3'b001, ctl(4'b0000, 2'b00, SEL_SUB, 1'b0));
    step("sub_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_SUB, 1'b0));
    step("sub_wb",  3'b100, ctl(4'b0010, 2'b00, SEL_SUB, 1'b0));

    // addi, ori
    Op = 6'b001000;
    step("addi_if",  3'b000, IFC);
    step("addi_id",  3'b001, ctl(4'b0000, 2'b00, SEL_ADDI, 1'b0));
    step("addi_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_ADDI, 1'b0));
    step("addi_wb",  3'b100, ctl(4'b0010, 2'b00, SEL_ADDI, 1'b0));
    Op = 6'b001101;
    step("ori_if",  3'b000, IFC);
    step("ori_id",  3'b001, ctl(4'b0000, 2'b00, SEL_ORI, 1'b0));
    step("ori_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_ORI, 1'b0));
    step("ori_wb",  3'b100, ctl(4'b0010, 2'b00, SEL_ORI, 1'b0));

    // lw: 5 cycles
    Op = 6'b100011;
    step("lw_if",  3'b000, IFC);
    step("lw_id",  3'b001, ctl(4'b0000, 2'b00, SEL_LW, 1'b0));
    step("lw_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_LW, 1'b0));
    step("lw_mem", 3'b011, ctl(4'b0000, 2'b00, SEL_LW, 1'b0));
    step("lw_wb",  3'b100, ctl(4'b0010, 2'b00, SEL_LW, 1'b0));

    // sw: MEM writes, then straight back to IF
    Op = 6'b101011;
    step("sw_if",  3'b000, IFC);
    step("sw_id",  3'b001, ctl(4'b0000, 2'b00, SEL_SW, 1'b0));
    step("sw_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_SW, 1'b0));
    step("sw_mem", 3'b011, ctl(4'b0001, 2'b00, SEL_SW, 1'b0));

    // beq taken (Z=1), not taken (Z=0)
    Op = 6'b000100; Z = 1'b1;
    step("beq1_if",  3'b000, IFC);
    step("beq1_id",  3'b001, ctl(4'b0000, 2'b00, SEL_BR, 1'b0));
    step("beq1_exe", 3'b010, ctl(4'b1000, 2'b10, SEL_BR, 1'b0));
    Z = 1'b0;
    step("beq0_if",  3'b000, IFC);
    step("beq0_id",  3'b001, ctl(4'b0000, 2'b00, SEL_BR, 1'b0));
    step("beq0_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_BR, 1'b0));

    // bne taken (Z=0), not taken (Z=1)
    Op = 6'b000101;
    step("bne0_if",  3'b000, IFC);
    step("bne0_id",  3'b001, ctl(4'b0000, 2'b00, SEL_BR, 1'b0));
    step("bne0_exe", 3'b010, ctl(4'b1000, 2'b10, SEL_BR, 1'b0));
    Z = 1'b1;
    step("bne1_if",  3'b000, IFC);
    step("bne1_id",  3'b001, ctl(4'b0000, 2'b00, SEL_BR, 1'b0));
    step("bne1_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_BR, 1'b0));
    Z = 1'b0;

    // j: 2 cycles
    Op = 6'b000010;
    step("j_if", 3'b000, IFC);
    step("j_id", 3'b001, ctl(4'b1000, 2'b11, SEL_NONE, 1'b0));

    // illegal opcode and illegal funct
    Op = 6'b111111;
    step("ill_op_if", 3'b000, IFC);
    step("ill_op_id", 3'b001, ctl(4'b0000, 2'b00, SEL_NONE, 1'b1));
    Op = 6'b000000; Func = 6'b000000;
    step("ill_fn_if", 3'b000, IFC);
    step("ill_fn_id", 3'b001, ctl(4'b0000, 2'b00, SEL_NONE, 1'b1));

    // reset asserted mid-EXE of an add
    Func = 6'b100000;
    step("rst_add_if", 3'b000, IFC);
    step("rst_add_id", 3'b001, ctl(4'b0000, 2'b00, SEL_ADD, 1'b0));
    #3 Clrn = 1'b0;
    #1;
    chk("rst_async/state", 32'(State), 32'(3'b000));
    chk("rst_async/ctl", 32'(obs), 32'(ZERO));
    @(negedge Clk);
    #1;
    chk("rst_hold/state", 32'(State), 32'(3'b000));
    chk("rst_hold/ctl", 32'(obs), 32'(ZERO));
    Clrn = 1'b1;
    step("rst_rel_if",  3'b000, IFC);
    step("rst_rel_id",  3'b001, ctl(4'b0000, 2'b00, SEL_ADD, 1'b0));
    step("rst_rel_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_ADD, 1'b0));
    step("rst_rel_wb",  3'b100, ctl(4'b0010, 2'b00, SEL_ADD, 1'b0));

`ifdef MEM_WAIT_EN
    // sw with 3 stall cycles: MEM lasts 4 cycles, Wmem held throughout
    Op = 6'b101011; Mrdy = 1'b0;
    step("swst_if",  3'b000, IFC);
    step("swst_id",  3'b001, ctl(4'b0000, 2'b00, SEL_SW, 1'b0));
    step("swst_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_SW, 1'b0));
    step("swst_m1",  3'b011, ctl(4'b0001, 2'b00, SEL_SW, 1'b0));
    step("swst_m2",  3'b011, ctl(4'b0001, 2'b00, SEL_SW, 1'b0));
    step("swst_m3",  3'b011, ctl(4'b0001, 2'b00, SEL_SW, 1'b0));
    Mrdy = 1'b1;
    step("swst_m4",  3'b011, ctl(4'b0001, 2'b00, SEL_SW, 1'b0));

    // lw with the same stall reaches WB on cycle 8
    Op = 6'b100011; Mrdy = 1'b0;
    step("lwst_if",  3'b000, IFC);
    step("lwst_id",  3'b001, ctl(4'b0000, 2'b00, SEL_LW, 1'b0));
    step("lwst_exe", 3'b010, ctl(4'b0000, 2'b00, SEL_LW, 1'b0));
    step("lwst_m1",  3'b011, ctl(4'b0000, 2'b00, SEL_LW, 1'b0));
    step("lwst_m2",  3'b011, ctl(4'b0000, 2'b00, SEL_LW, 1'b0));
    step("lwst_m3",  3'b011, ctl(4'b0000, 2'b00, SEL_LW, 1'b0));
    Mrdy = 1'b1;
    step("lwst_m4",  3'b011, ctl(4'b0000, 2'b00, SEL_LW, 1'b0));
    step("lwst_wb",  3'b100, ctl(4'b0010, 2'b00, SEL_LW, 1'b0));
`endif

    step("end_if", 3'b000, IFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
